// File: rtl/m_mem_port_arbiter_if.sv
// Memory-port arbiter bus bundle: three requester ports plus the single
// downstream interconnect port. The arbiter uses the slave view; the
// requesters/interconnect side (or a bench) uses the master view.
interface m_mem_port_arbiter_if #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32
);
  logic [2:0]        w_req;
  logic [W_ADDR-1:0] w_addr0;
  logic [W_ADDR-1:0] w_addr1;
  logic [W_ADDR-1:0] w_addr2;
  logic [2:0]        w_we;
  logic [W_DATA-1:0] w_wdata0;
  logic [W_DATA-1:0] w_wdata1;
  logic [W_DATA-1:0] w_wdata2;
  logic [2:0]        w_resp;
  logic [W_DATA-1:0] w_rdata;
  logic              w_ic_req;
  logic [W_ADDR-1:0] w_ic_addr;
  logic              w_ic_we;
  logic [W_DATA-1:0] w_ic_wdata;
  logic              w_ic_resp;
  logic [W_DATA-1:0] w_ic_rdata;
  logic              w_busy;

  modport slave (
    input  w_req, w_addr0, w_addr1, w_addr2, w_we, w_wdata0, w_wdata1, w_wdata2,
    input  w_ic_resp, w_ic_rdata,
    output w_resp, w_rdata, w_ic_req, w_ic_addr, w_ic_we, w_ic_wdata, w_busy
  );

  modport master (
    output w_req, w_addr0, w_addr1, w_addr2, w_we, w_wdata0, w_wdata1, w_wdata2,
    output w_ic_resp, w_ic_rdata,
    input  w_resp, w_rdata, w_ic_req, w_ic_addr, w_ic_we, w_ic_wdata, w_busy
  );
endinterface

// File: rtl/m_mem_port_arbiter.sv
// Shares one interconnect memory port between the page-table walker (port 0),
// I$ (port 1) and D$ (port 2). One transaction outstanding at a time; walker
// has priority bounded by a burst guard, the caches alternate round-robin.
//
// state | meaning
// IDLE  | no transaction in flight, arbitrating among candidates
// BUSY  | one downstream transaction outstanding, waiting for w_ic_resp
module m_mem_port_arbiter #(
  parameter int W_ADDR        = 32,
  parameter int W_DATA        = 32,
  parameter int PTW_BURST_MAX = 4
) (
  input logic              CLK,
  input logic              RST,
  m_mem_port_arbiter_if.slave bus
);
  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam logic [3:0] BURST_MAX = 4'(PTW_BURST_MAX);

  state_e                     state_q, state_d;
  logic [2:0]                 pending_q, pending_d;
  logic [2:0][W_ADDR-1:0]     lat_addr_q, lat_addr_d;
  logic [2:0]                 lat_we_q, lat_we_d;
  logic [2:0][W_DATA-1:0]     lat_wdata_q, lat_wdata_d;
  logic                       rr_ptr_q, rr_ptr_d;
  logic [3:0]                 burst_cnt_q, burst_cnt_d;
  logic [1:0]                 grant_q, grant_d;
  logic                       ic_req_q, ic_req_d;
  logic [W_ADDR-1:0]          ic_addr_q, ic_addr_d;
  logic                       ic_we_q, ic_we_d;
  logic [W_DATA-1:0]          ic_wdata_q, ic_wdata_d;
  logic [W_DATA-1:0]          rdata_q, rdata_d;

  logic [2:0][W_ADDR-1:0]     live_addr;
  logic [2:0][W_DATA-1:0]     live_wdata;
  logic [2:0]                 grant_oh, in_service, accepted, cand;
  logic                       resp_fire, cache_cand, gnt_valid;
  logic [1:0]                 gnt_idx;

  assign live_addr  = {bus.w_addr2, bus.w_addr1, bus.w_addr0};
  assign live_wdata = {bus.w_wdata2, bus.w_wdata1, bus.w_wdata0};
  assign grant_oh   = 3'b001 << grant_q;
  // The port being answered this cycle is free again, so it may re-request back-to-back.
  assign resp_fire  = (state_q == S_BUSY) && bus.w_ic_resp;
  assign in_service = (state_q == S_BUSY && !resp_fire) ? grant_oh : 3'b000;
  assign accepted   = bus.w_req & ~pending_q & ~in_service;
  assign cand       = pending_q | accepted;
  assign cache_cand = |cand[2:1];

  assign bus.w_ic_req   = ic_req_q;
  assign bus.w_ic_addr  = ic_addr_q;
  assign bus.w_ic_we    = ic_we_q;
  assign bus.w_ic_wdata = ic_wdata_q;
  assign bus.w_busy     = (state_q == S_BUSY);
  assign bus.w_resp     = resp_fire ? grant_oh : 3'b000;
  assign bus.w_rdata    = resp_fire ? bus.w_ic_rdata : rdata_q;

  // Grant selection: walker first unless its burst guard has tripped against a waiting cache.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    if (state_q == S_IDLE) begin
      if (cand[0] && !(burst_cnt_q == BURST_MAX && cache_cand)) begin
        gnt_valid = 1'b1;
        gnt_idx   = 2'd0;
      end else if (cache_cand) begin
        gnt_valid = 1'b1;
        if (!rr_ptr_q) gnt_idx = cand[1] ? 2'd1 : 2'd2;
        else           gnt_idx = cand[2] ? 2'd2 : 2'd1;
      end
    end
  end

  // Next-state: request latches, pending bits, FSM, downstream command and read-data hold.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q | accepted;
    lat_addr_d  = lat_addr_q;
    lat_we_d    = lat_we_q;
    lat_wdata_d = lat_wdata_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    grant_d     = grant_q;
    ic_req_d    = 1'b0;
    ic_addr_d   = ic_addr_q;
    ic_we_d     = ic_we_q;
    ic_wdata_d  = ic_wdata_q;
    rdata_d     = rdata_q;

    for (int i = 0; i < 3; i++) begin
      if (accepted[i]) begin
        lat_addr_d[i]  = live_addr[i];
        lat_we_d[i]    = bus.w_we[i];
        lat_wdata_d[i] = live_wdata[i];
      end
    end

    case (state_q)
      S_IDLE: begin
        if (gnt_valid) begin
          state_d            = S_BUSY;
          grant_d            = gnt_idx;
          pending_d[gnt_idx] = 1'b0;
          ic_req_d           = 1'b1;
          // A port granted straight off its pulse has nothing latched yet.
          if (pending_q[gnt_idx]) begin
            ic_addr_d  = lat_addr_q[gnt_idx];
            ic_we_d    = lat_we_q[gnt_idx];
            ic_wdata_d = lat_wdata_q[gnt_idx];
          end else begin
            ic_addr_d  = live_addr[gnt_idx];
            ic_we_d    = bus.w_we[gnt_idx];
            ic_wdata_d = live_wdata[gnt_idx];
          end
          if (gnt_idx == 2'd0) begin
            if (!cache_cand)                 burst_cnt_d = 4'd0;
            else if (burst_cnt_q != BURST_MAX) burst_cnt_d = burst_cnt_q + 4'd1;
          end else begin
            burst_cnt_d = 4'd0;
            rr_ptr_d    = (gnt_idx == 2'd1);
          end
        end
      end
      S_BUSY: begin
        if (bus.w_ic_resp) begin
          state_d = S_IDLE;
          rdata_d = bus.w_ic_rdata;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction and all pending requests.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pending_q   <= '0;
      lat_addr_q  <= '0;
      lat_we_q    <= '0;
      lat_wdata_q <= '0;
      rr_ptr_q    <= 1'b0;
      burst_cnt_q <= '0;
      grant_q     <= '0;
      ic_req_q    <= 1'b0;
      ic_addr_q   <= '0;
      ic_we_q     <= 1'b0;
      ic_wdata_q  <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      lat_addr_q  <= lat_addr_d;
      lat_we_q    <= lat_we_d;
      lat_wdata_q <= lat_wdata_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      grant_q     <= grant_d;
      ic_req_q    <= ic_req_d;
      ic_addr_q   <= ic_addr_d;
      ic_we_q     <= ic_we_d;
      ic_wdata_q  <= ic_wdata_d;
      rdata_q     <= rdata_d;
    end
  end
endmodule

// File: tb/tb_m_mem_port_arbiter.sv
// Directed cycle-by-cycle vectors for the memory-port arbiter, followed by a
// hand-written latency sequence. Inputs change 1ns after the rising edge,
// outputs are sampled on the falling edge.
module tb_m_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  m_mem_port_arbiter_if #(.W_ADDR(32), .W_DATA(32)) bus ();

  m_mem_port_arbiter #(.W_ADDR(32), .W_DATA(32), .PTW_BURST_MAX(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [2:0]  req;
    logic [31:0] a0, a1, a2;
    logic [2:0]  we;
    logic [31:0] wd;
    logic        icr;
    logic [31:0] icd;
    logic        e_req;
    logic [2:0]  e_resp;
    logic [31:0] e_rd;
    logic        e_busy;
    logic        chk;
    logic [31:0] e_addr;
    logic        e_we;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic rst_i, input logic [2:0] req, input logic [31:0] a0, a1, a2,
                             input logic [2:0] we, input logic [31:0] wd, input logic icr, input logic [31:0] icd,
                             input logic e_req, input logic [2:0] e_resp, input logic [31:0] e_rd, input logic e_busy,
                             input logic chk, input logic [31:0] e_addr, input logic e_we, input logic [31:0] e_wd);
    vec_t t;
    t.rst = rst_i; t.req = req; t.a0 = a0; t.a1 = a1; t.a2 = a2; t.we = we; t.wd = wd;
    t.icr = icr; t.icd = icd; t.e_req = e_req; t.e_resp = e_resp; t.e_rd = e_rd; t.e_busy = e_busy;
    t.chk = chk; t.e_addr = e_addr; t.e_we = e_we; t.e_wd = e_wd;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst          = t.rst;
    bus.w_req    = t.req;
    bus.w_addr0  = t.a0;
    bus.w_addr1  = t.a1;
    bus.w_addr2  = t.a2;
    bus.w_we     = t.we;
    bus.w_wdata0 = t.wd;
    bus.w_wdata1 = t.wd;
    bus.w_wdata2 = t.wd;
    bus.w_ic_resp  = t.icr;
    bus.w_ic_rdata = t.icd;
  endtask

  localparam logic [31:0] J = 32'hFFFF_0000;

  initial begin
    int   lat;
    logic ok;
    bus.w_req = '0; bus.w_addr0 = '0; bus.w_addr1 = '0; bus.w_addr2 = '0; bus.w_we = '0;
    bus.w_wdata0 = '0; bus.w_wdata1 = '0; bus.w_wdata2 = '0; bus.w_ic_resp = 1'b0; bus.w_ic_rdata = '0;

    // reset state
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,                         0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                         0,0,0,0,1,0,0,0));
    // single I$ read
    tbl.push_back(v(0,3'b010,0,32'h8000_0010,0,0,0,0,0,        0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,0,1,1,32'h8000_0010,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,0,1,1,32'h8000_0010,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,0,1,1,32'h8000_0010,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'hDEAD_BEEF,             0,3'b010,32'hDEAD_BEEF,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,32'h1111_1111,             0,0,32'hDEAD_BEEF,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,                         0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0));
    // simultaneous pulses: PTW, I$, D$
    tbl.push_back(v(0,3'b111,32'h1000_0000,32'h1000_0004,32'h1000_0008,0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,0,1,1,32'h1000_0000,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0000_0A00,             0,3'b001,32'h0A00,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0A00,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0A00,1,1,32'h1000_0004,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0000_0A01,             0,3'b010,32'h0A01,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0A01,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0A01,1,1,32'h1000_0008,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0000_0A02,             0,3'b100,32'h0A02,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0A02,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,                         0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0));
    // starvation guard: 4 walker grants, then D$, then walker
    tbl.push_back(v(0,3'b101,32'h2000_0000,J,32'h3000_0000,0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,0,1,1,32'h2000_0000,0,0));
    tbl.push_back(v(0,3'b001,32'h2000_0010,J,J,0,0,1,32'h0B00, 0,3'b001,32'h0B00,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0B00,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0B00,1,1,32'h2000_0010,0,0));
    tbl.push_back(v(0,3'b001,32'h2000_0020,J,J,0,0,1,32'h0B01, 0,3'b001,32'h0B01,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0B01,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0B01,1,1,32'h2000_0020,0,0));
    tbl.push_back(v(0,3'b001,32'h2000_0030,J,J,0,0,1,32'h0B02, 0,3'b001,32'h0B02,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0B02,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0B02,1,1,32'h2000_0030,0,0));
    tbl.push_back(v(0,3'b001,32'h2000_0040,J,J,0,0,1,32'h0B03, 0,3'b001,32'h0B03,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0B03,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0B03,1,1,32'h3000_0000,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0C00,                  0,3'b100,32'h0C00,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0C00,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0C00,1,1,32'h2000_0040,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0B04,                  0,3'b001,32'h0B04,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0B04,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,                         0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0));
    // round-robin I$/D$, pulses from an already-pending port are dropped
    tbl.push_back(v(0,3'b110,J,32'h4000_0000,32'h5000_0000,0,0,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,0,1,1,32'h4000_0000,0,0));
    tbl.push_back(v(0,3'b110,J,32'h4000_0100,32'h6666_0000,0,0,1,32'h0D00, 0,3'b010,32'h0D00,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0D00,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0D00,1,1,32'h5000_0000,0,0));
    tbl.push_back(v(0,3'b110,J,32'h6666_0000,32'h5000_0100,0,0,1,32'h0D01, 0,3'b100,32'h0D01,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0D01,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0D01,1,1,32'h4000_0100,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0D02,                  0,3'b010,32'h0D02,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0D02,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,32'h0D02,1,1,32'h5000_0100,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0D03,                  0,3'b100,32'h0D03,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0D03,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0D03,0,0,0,0,0));
    tbl.push_back(v(1,0,0,0,0,0,0,0,0,                         0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0,0,0,0,                         0,0,0,0,0,0,0,0));
    // D$ write, reset while busy, late response ignored
    tbl.push_back(v(0,3'b100,J,J,32'h8000_0100,3'b100,32'h1234_5678,0,0, 0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         1,0,0,1,1,32'h8000_0100,1,32'h1234_5678));
    tbl.push_back(v(1,0,J,J,J,0,0,0,0,                         0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0000_0BAD,             0,0,0,0,1,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,0,0,1,0,0,0));
    // duplicate pulses: while pending and while in service
    tbl.push_back(v(0,3'b001,32'h7000_0000,J,J,0,0,0,0,        0,0,0,0,0,0,0,0));
    tbl.push_back(v(0,3'b010,J,32'h7100_0000,J,0,0,0,0,        1,0,0,1,1,32'h7000_0000,0,0));
    tbl.push_back(v(0,3'b010,J,32'h7200_0000,J,0,0,0,0,        0,0,0,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0E00,                  0,3'b001,32'h0E00,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0E00,0,0,0,0,0));
    tbl.push_back(v(0,3'b010,J,32'h7300_0000,J,0,0,0,0,        1,0,32'h0E00,1,1,32'h7100_0000,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,1,32'h0E01,                  0,3'b010,32'h0E01,1,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0E01,0,0,0,0,0));
    tbl.push_back(v(0,0,J,J,J,0,0,0,0,                         0,0,32'h0E01,0,0,0,0,0));

    @(posedge clk); #1;
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk("ic_req", i, 32'(bus.w_ic_req), 32'(tbl[i].e_req));
      chk("resp",   i, 32'(bus.w_resp),   32'(tbl[i].e_resp));
      chk("rdata",  i, bus.w_rdata,       tbl[i].e_rd);
      chk("busy",   i, 32'(bus.w_busy),   32'(tbl[i].e_busy));
      if (tbl[i].chk) begin
        chk("ic_addr",  i, bus.w_ic_addr,      tbl[i].e_addr);
        chk("ic_we",    i, 32'(bus.w_ic_we),   32'(tbl[i].e_we));
        chk("ic_wdata", i, bus.w_ic_wdata,     tbl[i].e_wd);
      end
      @(posedge clk); #1;
    end

    // latency: req N -> ic_req N+1; resp M with re-pulse -> next ic_req at M+2
    bus.w_req = 3'b010; bus.w_addr1 = 32'h9000_0000;
    @(posedge clk); #1;
    bus.w_req = 3'b000; bus.w_addr1 = J;
    lat = 0; ok = 1'b0;
    for (int k = 1; k <= 8 && !ok; k++) begin
      @(negedge clk);
      if (bus.w_ic_req === 1'b1) begin ok = 1'b1; lat = k; end
      else begin @(posedge clk); #1; end
    end
    chk("lat_first", 100, 32'(lat), 32'd1);
    chk("lat_first_addr", 100, bus.w_ic_addr, 32'h9000_0000);
    @(posedge clk); #1;
    bus.w_ic_resp = 1'b1; bus.w_ic_rdata = 32'h0F00;
    bus.w_req = 3'b010; bus.w_addr1 = 32'h9000_0004;
    @(negedge clk);
    chk("lat_resp", 101, 32'(bus.w_resp), 32'(3'b010));
    chk("lat_rdata", 101, bus.w_rdata, 32'h0F00);
    @(posedge clk); #1;
    bus.w_ic_resp = 1'b0; bus.w_req = 3'b000; bus.w_addr1 = J;
    lat = 0; ok = 1'b0;
    for (int k = 1; k <= 8 && !ok; k++) begin
      @(negedge clk);
      if (bus.w_ic_req === 1'b1) begin ok = 1'b1; lat = k; end
      else begin @(posedge clk); #1; end
    end
    chk("lat_b2b", 102, 32'(lat), 32'd2);
    chk("lat_b2b_addr", 102, bus.w_ic_addr, 32'h9000_0004);
    @(posedge clk); #1;
    bus.w_ic_resp = 1'b1; bus.w_ic_rdata = 32'h0F01;
    @(negedge clk);
    chk("lat_b2b_resp", 103, 32'(bus.w_resp), 32'(3'b010));
    @(posedge clk); #1;
    bus.w_ic_resp = 1'b0;
    @(negedge clk);
    chk("lat_idle_busy", 104, 32'(bus.w_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
